// File: rtl/rib_uart_rx.sv
// RIB slave UART receiver: 8N1 deserializer feeding a receive FIFO that the CPU
// drains through CTRL/STATUS/BAUD/DATA registers, with a level interrupt.
module rib_uart_rx #(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        rx_pin,
    output logic        int_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_m, rx_s;
    logic          rx_en, int_en, overrun, frame_err;
    logic [15:0]   baud, div, cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [3:0] off;
    logic       wr_ctrl, wr_stat, wr_baud, wr_data;
    logic       empty, full, stop_tick, push, fe_set, do_push, do_pop, ov_set;
    logic [31:0] count_ext;
    logic [3:0]  count_sat;
    logic        unused_bits;

    assign off     = addr_i[3:0];
    assign wr_ctrl = we_i && (off == 4'h0);
    assign wr_stat = we_i && (off == 4'h4);
    assign wr_baud = we_i && (off == 4'h8);
    assign wr_data = we_i && (off == 4'hC);
    assign unused_bits = ^{addr_i[31:4], data_i[31:16]};

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign stop_tick = (state == STOP) && rx_en && (cnt == div - 16'd1);
    assign push      = stop_tick && rx_s;
    assign fe_set    = stop_tick && !rx_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_pop    = wr_data && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ov_set    = push && full && !do_pop;

    assign count_ext = 32'(count);
    assign count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

    always_comb begin
        data_o = '0;
        case (off)
            4'h0: data_o[1:0]  = {int_en, rx_en};
            4'h4: data_o[7:0]  = {count_sat, frame_err, overrun, full, !empty};
            4'h8: data_o[15:0] = baud;
            4'hC: if (!empty) data_o[7:0] = mem[rd_ptr];
            default: data_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en     <= 1'b0;
            int_en    <= 1'b0;
            baud      <= 16'(DEFAULT_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            int_o     <= 1'b0;
        end else begin
            if (wr_ctrl) {int_en, rx_en} <= data_i[1:0];
            if (wr_baud) baud <= (data_i[15:0] < 16'd16) ? 16'd16 : data_i[15:0];
            // Set events win over a same-cycle write-one-to-clear.
            overrun   <= ov_set | (overrun & ~(wr_stat & data_i[2]));
            frame_err <= fe_set | (frame_err & ~(wr_stat & data_i[3]));
            int_o     <= int_en & (!empty | overrun | frame_err);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div   <= 16'(DEFAULT_DIV);
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else if (state != IDLE && !rx_en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_en && !rx_s) begin
                        div   <= baud;
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == (div >> 1) - 16'd1) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == div - 16'd1) begin
                        shift[idx] <= rx_s;
                        cnt        <= '0;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == div - 16'd1) state <= IDLE;
                    else cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rib_uart_rx.sv
// Self-checking bench for rib_uart_rx: serial frames on rx_pin, register traffic on RIB,
// results compared against a queue-based model of the receive FIFO and flags.
module tb_rib_uart_rx;
    logic        clk = 1'b0;
    logic        rst, we_i, rx_pin;
    logic [31:0] addr_i, data_i, data_o;
    logic        int_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    bit         m_ov, m_fe;

    always #5 clk = ~clk;

    rib_uart_rx #(.DEFAULT_DIV(434), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .rx_pin(rx_pin), .int_o(int_o)
    );

    function automatic logic [31:0] exp_status();
        int c;
        logic [31:0] s;
        c = (q.size() > 15) ? 15 : q.size();
        s = '0;
        s[0] = (q.size() != 0);
        s[1] = (q.size() == 8);
        s[2] = m_ov;
        s[3] = m_fe;
        s[7:4] = c[3:0];
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        return (q.size() == 0) ? 32'h0 : {24'h0, q[0]};
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; addr_i = {28'h0, a}; data_i = d;
        @(negedge clk);
        we_i = 1'b0; data_i = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr_i = {28'h0, a};
        #1 d = data_o;
    endtask

    task automatic pop_model();
        if (q.size() != 0) void'(q.pop_front());
    endtask

    // Drives one 8N1 frame; the model only records it when the receiver is expected to see it.
    task automatic send_byte(input logic [7:0] b, input int div, input bit stop, input bit counted);
        logic v;
        @(posedge clk); #1;
        for (int bi = 0; bi < 10; bi++) begin
            v = (bi == 0) ? 1'b0 : (bi == 9) ? stop : b[bi-1];
            rx_pin = v;
            repeat (div) @(posedge clk);
            #1;
        end
        rx_pin = 1'b1;
        if (counted) begin
            if (!stop) m_fe = 1'b1;
            else if (q.size() < 8) q.push_back(b);
            else m_ov = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete(); m_ov = 0; m_fe = 0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_reset();
        bus_read(4'h0, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h want %h", r, 32'h0); end
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want %h", r, 32'h0); end
        bus_read(4'h8, r); n_cmp++;
        if (r !== 32'd434) begin n_err++; $display("FAIL reset_baud got %h want %h", r, 32'd434); end
        bus_read(4'hC, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want %h", r, 32'h0); end
        n_cmp++;
        if (int_o !== 1'b0) begin n_err++; $display("FAIL reset_int got %b want 0", int_o); end
    endtask

    task automatic test_single();
        logic [31:0] r;
        logic [7:0]  b;
        bus_write(4'h8, 32'd16);
        bus_write(4'h0, 32'd1);
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            send_byte(b, 16, 1'b1, 1'b1);
            bus_read(4'h4, r); n_cmp++;
            if (r !== exp_status()) begin n_err++; $display("FAIL single_status got %h want %h", r, exp_status()); end
            bus_read(4'hC, r); n_cmp++;
            if (r !== exp_data()) begin n_err++; $display("FAIL single_data got %h want %h", r, exp_data()); end
            bus_write(4'hC, 32'h0); pop_model();
            bus_read(4'h4, r); n_cmp++;
            if (r !== exp_status()) begin n_err++; $display("FAIL single_status_pop got %h want %h", r, exp_status()); end
            bus_read(4'hC, r); n_cmp++;
            if (r !== 32'h0) begin n_err++; $display("FAIL single_data_pop got %h want 0", r); end
        end
        bus_write(4'hC, 32'h0);
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL pop_empty_status got %h want 0", r); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        bus_write(4'h0, 32'd3);
        for (int k = 0; k < 9; k++) begin
            send_byte(8'($urandom_range(0, 255)), 16, 1'b1, 1'b1);
            if (k == 7) begin
                bus_read(4'h4, r); n_cmp++;
                if (r !== 32'h83 || r !== exp_status()) begin n_err++; $display("FAIL fill8_status got %h want %h", r, 32'h83); end
            end
        end
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h87 || r !== exp_status()) begin n_err++; $display("FAIL overrun_status got %h want %h", r, 32'h87); end
        n_cmp++;
        if (int_o !== 1'b1) begin n_err++; $display("FAIL overrun_int got %b want 1", int_o); end
        bus_write(4'h4, 32'h4); m_ov = 0;
        bus_read(4'h4, r); n_cmp++;
        if (r !== exp_status()) begin n_err++; $display("FAIL ov_clear_status got %h want %h", r, exp_status()); end
        for (int k = 0; k < 8; k++) begin
            bus_read(4'hC, r); n_cmp++;
            if (r !== exp_data()) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", k, r, exp_data()); end
            bus_write(4'hC, 32'h0); pop_model();
        end
        n_cmp++;
        if (int_o !== 1'b1) begin n_err++; $display("FAIL int_hold_after_last_pop got %b want 1", int_o); end
        @(negedge clk); n_cmp++;
        if (int_o !== 1'b0) begin n_err++; $display("FAIL int_drop_after_last_pop got %b want 0", int_o); end
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL drained_status got %h want 0", r); end
    endtask

    task automatic test_frame_err();
        logic [31:0] r;
        send_byte(8'h3C, 16, 1'b0, 1'b1);
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h08 || r !== exp_status()) begin n_err++; $display("FAIL frame_err_status got %h want %h", r, 32'h08); end
        bus_write(4'h4, 32'h8); m_fe = 0;
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL frame_err_clear got %h want 0", r); end
    endtask

    task automatic test_false_start();
        logic [31:0] r;
        @(posedge clk); #1;
        rx_pin = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_pin = 1'b1;
        repeat (40) @(posedge clk);
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL false_start_status got %h want 0", r); end
        send_byte(8'h5A, 16, 1'b1, 1'b1);
        bus_read(4'hC, r); n_cmp++;
        if (r !== 32'h5A) begin n_err++; $display("FAIL after_false_start_data got %h want 5a", r); end
        bus_write(4'hC, 32'h0); pop_model();
    endtask

    task automatic test_pop_on_push();
        logic [31:0] r;
        logic [7:0]  b;
        logic        v;
        for (int k = 0; k < 8; k++) send_byte(8'($urandom_range(0, 255)), 16, 1'b1, 1'b1);
        b = 8'($urandom_range(0, 255));
        // Start seen 3 edges after the falling edge; stop sampled 152 edges later.
        addr_i = 32'hC;
        @(posedge clk); #1;
        for (int c = 0; c < 160; c++) begin
            v = (c < 16) ? 1'b0 : (c >= 144) ? 1'b1 : b[c/16 - 1];
            rx_pin = v;
            we_i = (c == 154);
            @(posedge clk); #1;
        end
        we_i = 1'b0;
        pop_model(); q.push_back(b);
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h83 || r !== exp_status()) begin n_err++; $display("FAIL pop_on_push_status got %h want %h", r, 32'h83); end
        for (int k = 0; k < 8; k++) begin
            bus_read(4'hC, r); n_cmp++;
            if (r !== exp_data()) begin n_err++; $display("FAIL pop_on_push_data[%0d] got %h want %h", k, r, exp_data()); end
            bus_write(4'hC, 32'h0); pop_model();
        end
    endtask

    task automatic test_baud_change();
        logic [31:0] r;
        logic [7:0]  b1, b2;
        bus_write(4'h8, 32'd5);
        bus_read(4'h8, r); n_cmp++;
        if (r !== 32'd16) begin n_err++; $display("FAIL baud_floor got %0d want 16", r); end
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        fork
            send_byte(b1, 16, 1'b1, 1'b1);
            begin repeat (40) @(posedge clk); bus_write(4'h8, 32'd32); end
        join
        bus_read(4'hC, r); n_cmp++;
        if (r !== {24'h0, b1}) begin n_err++; $display("FAIL baud_old_frame got %h want %h", r, b1); end
        bus_write(4'hC, 32'h0); pop_model();
        send_byte(b2, 32, 1'b1, 1'b1);
        bus_read(4'hC, r); n_cmp++;
        if (r !== {24'h0, b2}) begin n_err++; $display("FAIL baud_new_frame got %h want %h", r, b2); end
        bus_write(4'hC, 32'h0); pop_model();
        bus_write(4'h8, 32'd16);
    endtask

    task automatic test_rx_en_off();
        logic [31:0] r;
        bus_write(4'h0, 32'd1);
        fork
            send_byte(8'($urandom_range(0, 255)), 16, 1'b1, 1'b0);
            begin repeat (70) @(posedge clk); bus_write(4'h0, 32'd0); end
        join
        bus_write(4'h0, 32'd1);
        repeat (40) @(posedge clk);
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL rx_en_off_status got %h want 0", r); end
        send_byte(8'($urandom_range(0, 255)), 16, 1'b1, 1'b1);
        bus_read(4'hC, r); n_cmp++;
        if (r !== exp_data()) begin n_err++; $display("FAIL rx_en_resume_data got %h want %h", r, exp_data()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bus_write(4'h0, 32'd3);
        fork
            send_byte(8'($urandom_range(0, 255)), 16, 1'b1, 1'b0);
            begin repeat (60) @(posedge clk); do_reset(); end
        join
        bus_read(4'h0, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL rst_mid_ctrl got %h want 0", r); end
        bus_read(4'h4, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL rst_mid_status got %h want 0", r); end
        bus_read(4'h8, r); n_cmp++;
        if (r !== 32'd434) begin n_err++; $display("FAIL rst_mid_baud got %h want %h", r, 32'd434); end
        bus_read(4'hC, r); n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h want 0", r); end
        n_cmp++;
        if (int_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_int got %b want 0", int_o); end
    endtask

    initial begin
        rst = 1'b1; we_i = 1'b0; addr_i = '0; data_i = '0; rx_pin = 1'b1;
        m_ov = 0; m_fe = 0;
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_false_start();
        test_pop_on_push();
        test_baud_change();
        test_rx_en_off();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
